// File: rtl/request_arbiter_l2.sv
// Round-robin arbiter funnelling N_MASTER request initiators into one L2 bank port
// through a one-entry output register with single-cycle grant-to-request latency.
module request_arbiter_l2 #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_MASTER
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTER-1:0]              data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]   data_add_i,
    input  logic [N_MASTER-1:0]              data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]     data_be_i,
    output logic [N_MASTER-1:0]              data_gnt_o,
    output logic                             data_req_o,
    output logic [ADDR_WIDTH-1:0]            data_add_o,
    output logic                             data_wen_o,
    output logic [DATA_WIDTH-1:0]            data_wdata_o,
    output logic [BE_WIDTH-1:0]              data_be_o,
    output logic [ID_WIDTH-1:0]              data_ID_o,
    input  logic                             data_gnt_i
);

    localparam int PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] add_q, add_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic                  slot_free;
    logic                  found;
    logic [PTR_W-1:0]      idx;
    logic [PTR_W-1:0]      win;
    logic [N_MASTER-1:0]   gnt;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        slot_free = (state_q == EMPTY) || data_gnt_i;
        found     = 1'b0;
        idx       = '0;
        win       = '0;
        gnt       = '0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        add_d     = add_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        id_d      = id_q;

        // NOTE: blocking assignments inside always_comb let the search carry
        // 'found' from one iteration to the next within the same evaluation.
        if (slot_free) begin
            for (int i = 0; i < N_MASTER; i++) begin
                idx = ptr_q + PTR_W'(i);
                if (!found && data_req_i[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end

        if (found) begin
            gnt[win] = 1'b1;
            state_d  = FULL;
            ptr_d    = win + PTR_W'(1);
            add_d    = data_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            wen_d    = data_wen_i[win];
            wdata_d  = data_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            be_d     = data_be_i[int'(win)*BE_WIDTH +: BE_WIDTH];
            id_d     = ID_WIDTH'(1) << win;
        end else if (state_q == FULL && data_gnt_i) begin
            state_d = EMPTY;
        end
    end

    // NOTE: the payload flops carry the async reset too, since their contents
    // are visible on the outputs and must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            add_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            id_q    <= '0;
        end else begin
            // NOTE: non-blocking so all flops sample the pre-edge values together.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            add_q   <= add_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            id_q    <= id_d;
        end
    end

    // Grants are suppressed during reset so a discarded request is never re-granted.
    assign data_gnt_o   = rst_n ? gnt : '0;
    assign data_req_o   = (state_q == FULL);
    assign data_add_o   = add_q;
    assign data_wen_o   = wen_q;
    assign data_wdata_o = wdata_q;
    assign data_be_o    = be_q;
    assign data_ID_o    = id_q;

endmodule

// File: tb/tb_request_arbiter_l2.sv
// Self-checking bench for request_arbiter_l2: table-driven grant vectors with a
// payload scoreboard, plus hand-written reset sequences.
module tb_request_arbiter_l2;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int IW = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      data_req_i;
    logic [N*AW-1:0]   data_add_i;
    logic [N-1:0]      data_wen_i;
    logic [N*DW-1:0]   data_wdata_i;
    logic [N*BW-1:0]   data_be_i;
    logic [N-1:0]      data_gnt_o;
    logic              data_req_o;
    logic [AW-1:0]     data_add_o;
    logic              data_wen_o;
    logic [DW-1:0]     data_wdata_o;
    logic [BW-1:0]     data_be_o;
    logic [IW-1:0]     data_ID_o;
    logic              data_gnt_i;

    request_arbiter_l2 #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_ID_o(data_ID_o),
        .data_gnt_i(data_gnt_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         gnt_i;
        logic [N-1:0] exp_gnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [IW-1:0] id;
    } pay_t;

    pay_t sb[$];
    pay_t last;
    logic exp_full;
    int   seed;
    int   n_checks;
    int   n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Distinct payload per initiator and per cycle, so a stale or wrong capture shows.
    function automatic pay_t payload_of(input int i, input int s);
        pay_t p;
        p.add   = AW'(i * 256 + s);
        p.wen   = 1'(i ^ s);
        p.wdata = {32'hA5A5_0000 + 32'(i), 32'(s)};
        p.be    = BW'((8'h1 << i) ^ s);
        p.id    = '0;
        return p;
    endfunction

    task automatic drive_payload(input int s);
        pay_t p;
        for (int i = 0; i < N; i++) begin
            p = payload_of(i, s);
            data_add_i[i*AW +: AW]   = p.add;
            data_wen_i[i]            = p.wen;
            data_wdata_i[i*DW +: DW] = p.wdata;
            data_be_i[i*BW +: BW]    = p.be;
        end
    endtask

    task automatic compare_out(input string tag, input pay_t e);
        check({tag, " add"},   64'(data_add_o),   64'(e.add));
        check({tag, " wen"},   64'(data_wen_o),   64'(e.wen));
        check({tag, " wdata"}, data_wdata_o,      e.wdata);
        check({tag, " be"},    64'(data_be_o),    64'(e.be));
        check({tag, " id"},    64'(data_ID_o),    64'(e.id));
    endtask

    // One cycle: drive at posedge+1, check grant before the edge, check registers after it.
    task automatic step(input logic [N-1:0] req, input logic gi, input logic [N-1:0] exp_gnt,
                        input string tag);
        pay_t e;
        logic next_full;
        seed++;
        data_req_i = req;
        data_gnt_i = gi;
        drive_payload(seed);
        #1;
        check({tag, " gnt"}, 64'(data_gnt_o), 64'(exp_gnt));
        if (exp_gnt != '0) begin
            for (int i = 0; i < N; i++) if (exp_gnt[i]) e = payload_of(i, seed);
            e.id = exp_gnt;
            sb.push_back(e);
            next_full = 1'b1;
        end else if (exp_full && gi) begin
            next_full = 1'b0;
        end else begin
            next_full = exp_full;
        end
        @(posedge clk);
        #1;
        exp_full = next_full;
        check({tag, " req_o"}, 64'(data_req_o), 64'(exp_full));
        if (sb.size() > 0) begin
            last = sb.pop_front();
            compare_out({tag, " cap"}, last);
        end else if (exp_full) begin
            compare_out({tag, " hold"}, last);
        end
    endtask

    vec_t vecs[$];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        seed     = 0;
        exp_full = 1'b0;
        last     = payload_of(0, 0);

        // Round robin over all four, then drain, stall, back-to-back and wrap-around.
        for (int r = 0; r < 2; r++) begin
            vecs.push_back('{4'b1111, 1'b1, 4'b0001});
            vecs.push_back('{4'b1111, 1'b1, 4'b0010});
            vecs.push_back('{4'b1111, 1'b1, 4'b0100});
            vecs.push_back('{4'b1111, 1'b1, 4'b1000});
        end
        vecs.push_back('{4'b0000, 1'b1, 4'b0000});  // drain to EMPTY
        vecs.push_back('{4'b0100, 1'b0, 4'b0100});  // empty slot accepts while bank stalls
        vecs.push_back('{4'b1011, 1'b0, 4'b0000});  // stalled: other requests ignored
        vecs.push_back('{4'b1011, 1'b0, 4'b0000});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000});
        vecs.push_back('{4'b0010, 1'b1, 4'b0010});  // back-to-back replacement
        vecs.push_back('{4'b0100, 1'b1, 4'b0100});  // pointer moves to 3
        vecs.push_back('{4'b1001, 1'b1, 4'b1000});  // 3 before 0
        vecs.push_back('{4'b0001, 1'b1, 4'b0001});  // then wrap to 0
        vecs.push_back('{4'b0000, 1'b1, 4'b0000});  // to EMPTY, pointer holds at 1
        vecs.push_back('{4'b0000, 1'b0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 4'b0010});
        vecs.push_back('{4'b1111, 1'b0, 4'b0000});
        vecs.push_back('{4'b0101, 1'b1, 4'b0100});
        vecs.push_back('{4'b0101, 1'b1, 4'b0001});
        vecs.push_back('{4'b0000, 1'b1, 4'b0000});

        // Reset with requests pending: outputs and grants must all read zero.
        rst_n      = 1'b0;
        data_req_i = 4'b1111;
        data_gnt_i = 1'b1;
        drive_payload(99);
        #3;
        check("rst gnt",   64'(data_gnt_o), 64'd0);
        check("rst req_o", 64'(data_req_o), 64'd0);
        check("rst add",   64'(data_add_o), 64'd0);
        check("rst id",    64'(data_ID_o),  64'd0);
        @(posedge clk);
        #1;
        check("rst edge req_o", 64'(data_req_o), 64'd0);
        data_req_i = '0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle req_o", 64'(data_req_o), 64'd0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].req, vecs[i].gnt_i, vecs[i].exp_gnt, $sformatf("vec%0d", i));

        // Fill the slot, then assert reset mid-cycle without a clock edge.
        step(4'b1000, 1'b0, 4'b1000, "pre-rst fill");
        data_req_i = 4'b1111;
        #3;
        rst_n = 1'b0;
        #1;
        check("async req_o", 64'(data_req_o), 64'd0);
        check("async add",   64'(data_add_o), 64'd0);
        check("async wdata", data_wdata_o,    64'd0);
        check("async be",    64'(data_be_o),  64'd0);
        check("async wen",   64'(data_wen_o), 64'd0);
        check("async id",    64'(data_ID_o),  64'd0);
        check("async gnt",   64'(data_gnt_o), 64'd0);
        @(posedge clk);
        #1;
        check("held rst req_o", 64'(data_req_o), 64'd0);
        data_req_i = '0;
        #2;
        rst_n = 1'b1;
        exp_full = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        // Pointer restarts at 0, so initiator 1 wins over 2.
        step(4'b0110, 1'b1, 4'b0010, "post-rst");
        step(4'b0100, 1'b1, 4'b0100, "post-rst 2");
        step(4'b0000, 1'b1, 4'b0000, "post-rst drain");

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/request_arbiter_l2.md
REQUEST_ARBITER_L2 -- requirements
Module: request_arbiter_l2

Interface
REQ-001 Parameter N_MASTER, default 4, SHALL set the number of request initiators; legal values are powers of two from 2 to 16.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the request address width.
REQ-003 Parameter DATA_WIDTH, default 64, SHALL set the write-data width.
REQ-004 Parameter BE_WIDTH, default DATA_WIDTH/8, SHALL set the byte-enable width.
REQ-005 Parameter ID_WIDTH, default N_MASTER, SHALL set the one-hot initiator ID width; it is used as the response tag.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-008 data_req_i  input  N_MASTER  SHALL carry the per-initiator request valid.
REQ-009 data_add_i  input  N_MASTER x ADDR_WIDTH  SHALL carry the per-initiator address.
REQ-010 data_wen_i  input  N_MASTER  SHALL carry the per-initiator write-enable, 1=read, 0=write.
REQ-011 data_wdata_i  input  N_MASTER x DATA_WIDTH  SHALL carry the per-initiator write data.
REQ-012 data_be_i  input  N_MASTER x BE_WIDTH  SHALL carry the per-initiator byte enables.
REQ-013 data_gnt_o  output  N_MASTER  SHALL carry the per-initiator grant, at most one bit set.
REQ-014 data_req_o  output  1  SHALL carry the request valid toward the L2 bank.
REQ-015 data_add_o, data_wen_o, data_wdata_o, data_be_o  output  ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH  SHALL carry the registered payload of the winning initiator.
REQ-016 data_ID_o  output  ID_WIDTH  SHALL carry the one-hot index of the initiator that owns the current output request.
REQ-017 data_gnt_i  input  1  SHALL carry the grant from the L2 bank; a transfer completes when data_req_o and data_gnt_i are both 1.

Function
REQ-018 The output stage SHALL be a one-entry register with two states: EMPTY (data_req_o=0) and FULL (data_req_o=1).
REQ-019 The slot is free in a cycle when the state is EMPTY, or when the state is FULL and data_gnt_i=1.
REQ-020 When the slot is free and any data_req_i bit is 1, exactly one data_gnt_o bit SHALL be 1 in the same cycle, combinationally; data_gnt_o SHALL be all zero otherwise.
REQ-021 The winner SHALL be the first requesting index at or after the round-robin pointer, searching upward with wrap-around from N_MASTER-1 to 0.
REQ-022 On a grant to index w, the pointer SHALL update to (w+1) mod N_MASTER at the next edge; with no grant, the pointer SHALL hold.
REQ-023 On a grant to index w, the payload of w SHALL be captured, data_ID_o SHALL become 1<<w, and the state SHALL be FULL at the next edge, giving one-cycle latency.
REQ-024 Transitions:
- EMPTY + grant -> FULL.
- FULL + data_gnt_i + grant -> FULL with the new payload (back-to-back, no bubble).
- FULL + data_gnt_i + no request -> EMPTY.
- FULL + !data_gnt_i -> FULL.
REQ-025 While FULL and data_gnt_i=0, all outputs except data_gnt_o SHALL hold stable.
REQ-026 Initiator inputs not granted in a cycle SHALL have no effect; initiators keep requesting until they are granted.
REQ-027 Sustained throughput SHALL be one request per cycle when data_gnt_i stays 1.
REQ-028 Under continuous requests from k initiators, each initiator SHALL be granted once every k grants (starvation-free).

Reset
REQ-029 While rst_n=0, regardless of clk:
- state SHALL be EMPTY and data_req_o=0.
- pointer SHALL be 0.
- data_add_o, data_wen_o, data_wdata_o, data_be_o and data_ID_o SHALL be 0.
REQ-030 A request held in the output register when reset asserts SHALL be discarded with no grant reissued; data_gnt_o SHALL be all zero while rst_n=0.
REQ-031 After rst_n deasserts, arbitration SHALL begin on the first rising edge, with the pointer at 0.

Verification
REQ-032 Reset, then data_req_i=4'b1111 with data_gnt_i=1 for 8 cycles -> data_gnt_o sequence 0001, 0010, 0100, 1000, repeating; data_req_o=1 from cycle 2; data_ID_o lags data_gnt_o by one cycle.
REQ-033 Initiator 2 requests with add=0x123, wen=0, be=0xFF while data_gnt_i=0 for 3 cycles -> data_gnt_o=0100 once; outputs hold add=0x123 and ID=0100 for 3 cycles; data_gnt_o=0000 until data_gnt_i=1.
REQ-034 FULL with data_gnt_i=1 and initiator 1 requesting -> data_gnt_o=0010 in the same cycle; the new payload appears on the next edge with no idle cycle.
REQ-035 Pointer at 3 with requests from initiators 0 and 3 -> initiator 3 is granted first, then initiator 0 (wrap-around).
REQ-036 Assert rst_n=0 mid-cycle while FULL -> data_req_o=0 immediately, without waiting for clk; after release, the first grant with requests from initiators 1 and 2 goes to initiator 1.
